// File: rtl/cbus_ram_responder_pkg.sv
// Shared CBus types plus the RAM responder state encoding.
package cbus_ram_responder_pkg;

  localparam int unsigned CBUS_ADDR_W = 32;
  localparam int unsigned CBUS_DATA_W = 64;
  localparam int unsigned CBUS_STRB_W = CBUS_DATA_W / 8;

  // Burst length code: beats = len + 1
  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } mlen_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'd0,
    AXI_BURST_INCR  = 2'd1,
    AXI_BURST_WRAP  = 2'd2
  } axi_burst_type_t;

  typedef struct packed {
    logic                   valid;
    logic                   is_write;
    logic [2:0]             size;
    logic [CBUS_ADDR_W-1:0] addr;
    logic [CBUS_STRB_W-1:0] strobe;
    logic [CBUS_DATA_W-1:0] data;
    mlen_t                  len;
    axi_burst_type_t        burst;
  } cbus_req_t;

  typedef struct packed {
    logic                   ready;
    logic                   last;
    logic [CBUS_DATA_W-1:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } cbus_ram_state_t;

endpackage

// File: rtl/cbus_ram_responder_stall_lfsr.sv
// Pseudo-random beat stall generator; used only when CBUS_RAM_RANDOM_STALL_EN is defined.
module stall_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  output logic stall_c
);

  logic [7:0] lfsr;
  logic [1:0] run;
  logic       fb;

  // Fibonacci taps 8,6,5,4
  assign fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  // A run of three stalls forces the next active cycle through
  assign stall_c = (lfsr[1:0] == 2'b00) && (run != 2'd3);

  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr <= SEED;
      run  <= '0;
    end else begin
      lfsr <= {lfsr[6:0], fb};
      run  <= (active && stall_c) ? run + 2'd1 : 2'd0;
    end
  end

endmodule

// File: rtl/cbus_ram_responder.sv
// CBus target backed by a word-addressed 64-bit RAM with byte-strobed writes.
// Optional random beat stalls are enabled with CBUS_RAM_RANDOM_STALL_EN.
module cbus_ram_responder
  import cbus_ram_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 4096,
  parameter int unsigned LATENCY    = 2,
  parameter logic [7:0]  STALL_SEED = 8'hA5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [$bits(cbus_req_t)-1:0]  creq,
  output logic [$bits(cbus_resp_t)-1:0] cresp
);

  localparam int unsigned IDX_BITS = $clog2(MEM_WORDS);
  localparam int unsigned CNT_BITS = 4;

  cbus_req_t           req;
  cbus_resp_t          resp;
  cbus_ram_state_t     state;
  cbus_ram_state_t     state_nxt;
  logic [CNT_BITS-1:0] cnt;
  logic [3:0]          beats_left;
  logic [IDX_BITS-1:0] idx;
  logic                wr_q;
  logic                fixed_q;
  logic                stall_c;
  logic                active_c;
  logic                beat_c;
  logic                unused_ok;
  logic [CBUS_DATA_W-1:0] mem [MEM_WORDS];

  assign req   = cbus_req_t'(creq);
  assign cresp = resp;

  assign active_c = (state == BURST) && req.valid;

`ifdef CBUS_RAM_RANDOM_STALL_EN
  stall_lfsr #(.SEED(STALL_SEED)) u_stall_lfsr (
    .clk     (clk),
    .reset   (reset),
    .active  (active_c),
    .stall_c (stall_c)
  );
  assign unused_ok = ^{req.size, req.addr[2:0], req.addr[CBUS_ADDR_W-1:IDX_BITS+3]};
`else
  assign stall_c   = 1'b0;
  assign unused_ok = ^{req.size, req.addr[2:0], req.addr[CBUS_ADDR_W-1:IDX_BITS+3], STALL_SEED};
`endif

  assign beat_c = active_c && !stall_c;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Dropped valid outside IDLE abandons the transaction
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (req.valid) state_nxt = (LATENCY > 0) ? WAIT : BURST;
      WAIT: begin
        if (!req.valid)                             state_nxt = IDLE;
        else if (cnt == CNT_BITS'(LATENCY - 1))     state_nxt = BURST;
      end
      BURST: begin
        if (!req.valid)                             state_nxt = IDLE;
        else if (beat_c && (beats_left == 4'd0))    state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    resp = '0;
    if (beat_c) begin
      resp.ready = 1'b1;
      resp.last  = (beats_left == 4'd0);
      resp.data  = wr_q ? '0 : mem[idx];
    end
  end

  // Transaction context: latched at acceptance, advanced per beat
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt        <= '0;
      beats_left <= '0;
      idx        <= '0;
      wr_q       <= 1'b0;
      fixed_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (req.valid) begin
            wr_q       <= req.is_write;
            fixed_q    <= (req.burst == AXI_BURST_FIXED);
            idx        <= req.addr[IDX_BITS+2:3];
            beats_left <= req.len;
          end
        end
        WAIT:  cnt <= cnt + CNT_BITS'(1);
        BURST: begin
          if (beat_c && (beats_left != 4'd0)) begin
            beats_left <= beats_left - 4'd1;
            if (!fixed_q) idx <= idx + IDX_BITS'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  // RAM is never cleared; byte lanes written independently
  always_ff @(posedge clk) begin
    if (reset && beat_c && wr_q) begin
      for (int b = 0; b < CBUS_STRB_W; b++) begin
        if (req.strobe[b]) mem[idx][8*b +: 8] <= req.data[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/cbus_ram_responder.md
Name: cbus_ram_responder

Overview:
- CBus target (responder) backing a word-addressed RAM; sits on the memory side of the CBus arbiter, consuming the arbitrated `oreq` and driving `oresp`.
- Accepts single and burst read/write transactions, applies byte strobes on writes, and returns one beat per `ready`, with `last` on the final beat.
- Serves as the simulation memory model and FPGA on-chip RAM target.

Parameters:
- MEM_WORDS, 4096: number of 64-bit words; power of two.
- LATENCY, 2: idle cycles between request acceptance and first beat; 0..15.
- STALL_SEED, 8'hA5: LFSR seed, used only with CBUS_RAM_RANDOM_STALL_EN.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous reset, active-low.
- creq  input  $bits(cbus_req_t)  request fields: valid, is_write, size, addr, strobe, data, len, burst.
- cresp  output  $bits(cbus_resp_t)  response fields: ready, last, data.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous, active-low. Reset asserted forces state IDLE, cnt=0 and cresp='0. RAM contents are not cleared.
- Reset mid-burst: abandons the transaction next edge; partial writes already committed remain.
- States: IDLE, WAIT, BURST.
- IDLE:
  - cresp='0.
  - On creq.valid, latch is_write, burst, word index = addr[$clog2(MEM_WORDS)+2:3] and beats_left = len (mlen_t encoding: beats = len+1).
  - Then go to WAIT if LATENCY>0, else BURST.
  - addr[2:0] ignored; upper address bits ignored (modulo wrap).
- WAIT: count LATENCY cycles, then BURST.
  - A request first seen at edge T gets its first ready in cycle T+1+LATENCY.
- BURST, each non-stalled cycle:
  - Assert ready=1.
  - Read: cresp.data = mem[idx], combinational from the current index.
  - Write: for each byte b with strobe[b]=1, mem[idx].byte[b] <= creq.data.byte[b] at the edge. cresp.data='0 on writes.
  - last=1 iff beats_left==0; decrement otherwise.
  - Index update: INCR burst increments index, wrapping at MEM_WORDS-1 -> 0. FIXED burst holds index.
- After a last beat: go to IDLE. A new request can be accepted on the first IDLE cycle, so there is no back-to-back acceptance in the last cycle.
- Protocol rule: initiator holds creq stable from acceptance through last. creq.data/strobe may change per beat on writes.
- creq.valid dropping in WAIT/BURST is a protocol violation. Responder returns to IDLE next edge, suppresses ready that cycle, and writes nothing.
- size is ignored; reads always return the full 64-bit word.
- ready is never asserted in IDLE or WAIT. last is never asserted without ready.

Optional Feature:
- CBUS_RAM_RANDOM_STALL_EN defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seeded STALL_SEED at reset) advances every cycle.
  - In BURST, a beat is stalled (ready=0, no index/count/mem update) when lfsr[1:0]==2'b00.
  - Stalls never exceed 3 consecutive cycles; a 4th forces ready.
- Undefined: no LFSR logic; every BURST cycle is a beat.

Decomposition:
- Shared package (common):
  - existing cbus_req_t, cbus_resp_t, mlen_t, axi_burst_type_t;
  - new cbus_ram_state_t enum {IDLE, WAIT, BURST}.
- Local localparam IDX_BITS = $clog2(MEM_WORDS).
- One sub-module, stall_lfsr: LFSR plus consecutive-stall limiter; instantiated only under the macro.

Test Plan:
- LATENCY=2, write single: addr 0x100, strobe 8'h0F, data 64'h1122334455667788, len MLEN1 -> one ready+last 3 cycles after accept. Then a read of 0x100 returns 64'h0000000055667788 (RAM preloaded to 0).
- INCR read burst, MLEN4 at 0x40 after writing words 8..11 = 0xA0..0xA3 -> four consecutive ready beats with data A0,A1,A2,A3, last only on the 4th.
- Wrap: MEM_WORDS=16, INCR write MLEN4 at addr 0x70 (index 14) -> indexes 14,15,0,1 written; read-back confirms.
- FIXED write burst MLEN4 at 0x20 with data 1,2,3,4 -> word 4 ends = 4, words 5..7 untouched.
- Reset asserted (reset=0) during beat 2 of an MLEN8 read -> cresp='0 next cycle. A new MLEN1 read after release completes normally.
- Macro defined, MLEN16 read -> exactly 16 ready beats, no run of >3 stalls, data sequence identical to the non-stall run.
